// File: rtl/seven_seg_capture_if.sv
// Bundle for the seven-segment capture monitor: sampled display bus in, captured result out.
// The master side drives the display lines; the slave side is the capture unit.
interface seven_seg_capture_if;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_flags;
  logic        frame_valid;
  logic        frame_ok;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output an, seg, clr,
    input  value, digit_valid, dp_flags, frame_valid, frame_ok, err, err_cnt
  );

  modport slave (
    input  an, seg, clr,
    output value, digit_valid, dp_flags, frame_valid, frame_ok, err, err_cnt
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Loopback monitor for the 4-digit common-anode display bus: waits for each {an, seg} pattern
// to settle, decodes it back to a hex nibble and reports frames/errors. SEVEN_SEG_CAPTURE_DP_EN enables dp tracking.
module seven_seg_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  seven_seg_capture_if.slave bus
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [7:0] segMasked;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  assign segMasked = bus.seg;
`else
  // Without dp tracking, seg[0] must not disturb the settle detector.
  logic unusedSeg0;
  assign unusedSeg0 = bus.seg[0];
  assign segMasked  = {bus.seg[7:1], 1'b1};
`endif

  logic [3:0]  anReg;
  logic [7:0]  segReg;
  logic [7:0]  stableCnt;
  logic        sampleEvt;
  logic [15:0] valueReg;
  logic [3:0]  validReg;
  logic [3:0]  seenReg;
  logic        frameValidReg;
  logic        frameOkReg;
  logic        errReg;
  logic [7:0]  errCntReg;

  logic [7:0]  cntNext;
  logic        evtNext;
  logic        anBlank;
  logic        anOneHot;
  logic [3:0]  selMask;
  logic        errNext;
  logic [3:0]  decNib;
  logic        decHit;

  always_comb begin
    cntNext = stableCnt;
    if ({bus.an, segMasked} != {anReg, segReg}) begin
      cntNext = 8'd0;
    end else if (stableCnt != SETTLE) begin
      cntNext = stableCnt + 8'd1;
    end
  end

  // Only the transition into the saturated count produces a sample.
  assign evtNext = (cntNext == SETTLE) && (stableCnt != SETTLE);

  assign anBlank  = (anReg == 4'hF);
  assign anOneHot = $onehot(~anReg);
  assign selMask  = (sampleEvt && anOneHot) ? ~anReg : 4'h0;
  assign errNext  = sampleEvt && !anBlank && !(anOneHot && decHit);

  always_comb begin
    decHit = 1'b1;
    decNib = 4'h0;
    case (~segReg[7:1])
      7'b1111110: decNib = 4'h0;
      7'b0110000: decNib = 4'h1;
      7'b1101101: decNib = 4'h2;
      7'b1111001: decNib = 4'h3;
      7'b0110011: decNib = 4'h4;
      7'b1011011: decNib = 4'h5;
      7'b1011111: decNib = 4'h6;
      7'b1110000: decNib = 4'h7;
      7'b1111111: decNib = 4'h8;
      7'b1111011: decNib = 4'h9;
      7'b1110111: decNib = 4'hA;
      7'b0011111: decNib = 4'hB;
      7'b1001110: decNib = 4'hC;
      7'b0111101: decNib = 4'hD;
      7'b1001111: decNib = 4'hE;
      7'b1000111: decNib = 4'hF;
      default:    decHit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      anReg         <= 4'hF;
      segReg        <= 8'hFF;
      stableCnt     <= 8'd0;
      sampleEvt     <= 1'b0;
      valueReg      <= 16'h0000;
      validReg      <= 4'h0;
      seenReg       <= 4'h0;
      frameValidReg <= 1'b0;
      frameOkReg    <= 1'b0;
      errReg        <= 1'b0;
    end else begin
      anReg         <= bus.an;
      segReg        <= segMasked;
      stableCnt     <= cntNext;
      sampleEvt     <= evtNext;
      errReg        <= errNext;
      frameValidReg <= (seenReg == 4'hF);
      frameOkReg    <= (seenReg == 4'hF) && (validReg == 4'hF);
      seenReg       <= ((seenReg == 4'hF) ? 4'h0 : seenReg) | selMask;
      for (int i = 0; i < 4; i++) begin
        if (selMask[i]) begin
          validReg[i] <= decHit;
          if (decHit) begin
            valueReg[4*i +: 4] <= decNib;
          end
        end
      end
    end
  end

  // The error counter survives clr; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      errCntReg <= 8'd0;
    end else if (!bus.clr && errNext && (errCntReg != 8'hFF)) begin
      errCntReg <= errCntReg + 8'd1;
    end
  end

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic [3:0] dpReg;

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      dpReg <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (selMask[i] && decHit) begin
          dpReg[i] <= ~segReg[0];
        end
      end
    end
  end

  assign bus.dp_flags = dpReg;
`else
  assign bus.dp_flags = 4'h0;
`endif

  assign bus.value       = valueReg;
  assign bus.digit_valid = validReg;
  assign bus.frame_valid = frameValidReg;
  assign bus.frame_ok    = frameOkReg;
  assign bus.err         = errReg;
  assign bus.err_cnt     = errCntReg;

endmodule
